// File: rtl/nes_multi_pad_poller.sv
// nes_multi_pad_poller: one shared latch/clock pair polls up to four
// NES or SNES pads in parallel and publishes buttons plus edge events.
module nes_multi_pad_poller #(
    parameter int NUM_PADS   = 2,
    parameter int BITS       = 8,
    parameter int CLK_DIV    = 300,
    parameter int POLL_TICKS = 2778,
    parameter int AUTO_POLL  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_PADS-1:0]      nesData,
    input  logic                     pollReq,
    output logic                     nesLatch,
    output logic                     nesClk,
    output logic [NUM_PADS*BITS-1:0] buttons,
    output logic                     buttonsValid,
    output logic [NUM_PADS*BITS-1:0] pressedEvt,
    output logic [NUM_PADS*BITS-1:0] releasedEvt,
    output logic                     busy
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        READ,
        PULSE,
        DONE
    } stateT;

    localparam int TOTAL = NUM_PADS * BITS;
    localparam int CW    = $clog2(CLK_DIV);
    localparam int IW    = $clog2(BITS);
    localparam int PW    = $clog2(POLL_TICKS + 1);

    localparam logic [CW-1:0] TICK_LAST = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(BITS - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_TICKS - 1);

    stateT               state;
    stateT               nextState;
    logic [NUM_PADS-1:0] syncA;
    logic [NUM_PADS-1:0] syncB;
    logic [CW-1:0]       tickCnt;
    logic                tick;
    logic [PW-1:0]       pollCnt;
    logic                reqPend;
    logic                autoDue;
    logic                startReq;
    logic                latchHalf;
    logic [IW-1:0]       idx;
    logic [BITS-1:0]     shiftReg [NUM_PADS];
    logic [TOTAL-1:0]    frameBits;

    // Two-flop synchroniser; idle pad lines float high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            syncA <= '1;
            syncB <= '1;
        end else begin
            syncA <= nesData;
            syncB <= syncA;
        end
    end

    // Free-running protocol tick divider.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tickCnt <= '0;
        end else if (tick) begin
            tickCnt <= '0;
        end else begin
            tickCnt <= tickCnt + CW'(1);
        end
    end

    assign tick     = (tickCnt == TICK_LAST);
    assign autoDue  = (AUTO_POLL != 0) && (pollCnt == POLL_LAST);
    assign startReq = pollReq || reqPend || autoDue;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; every protocol step advances on a tick.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (tick && startReq) nextState = LATCH;
            end
            LATCH: begin
                if (tick && latchHalf) nextState = READ;
            end
            READ: begin
                if (tick) begin
                    nextState = (idx == IDX_LAST) ? DONE : PULSE;
                end
            end
            PULSE: begin
                if (tick) nextState = READ;
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Pin drive and busy flag decoded from the state.
    always_comb begin
        nesLatch = 1'b0;
        nesClk   = 1'b1;
        busy     = 1'b1;
        unique case (state)
            IDLE:    busy     = 1'b0;
            LATCH:   nesLatch = 1'b1;
            PULSE:   nesClk   = 1'b0;
            default: ;
        endcase
    end

    // Poll timer, request capture, latch phase and bit index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pollCnt   <= '0;
            reqPend   <= 1'b0;
            latchHalf <= 1'b0;
            idx       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (nextState == LATCH) begin
                        pollCnt   <= '0;
                        reqPend   <= 1'b0;
                        latchHalf <= 1'b0;
                        idx       <= '0;
                    end else begin
                        if (pollReq) reqPend <= 1'b1;
                        if (tick && pollCnt != POLL_LAST) begin
                            pollCnt <= pollCnt + PW'(1);
                        end
                    end
                end
                LATCH: begin
                    if (tick) latchHalf <= 1'b1;
                end
                PULSE: begin
                    if (tick) idx <= idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

    // Each READ tick shifts one inverted sample in from the top, so the
    // first bit read lands in position 0 after BITS samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                shiftReg[p] <= '0;
            end
        end else if (state == READ && tick) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                shiftReg[p] <= {~syncB[p], shiftReg[p][BITS-1:1]};
            end
        end
    end

    for (genvar g = 0; g < NUM_PADS; g++) begin : gFlat
        assign frameBits[g*BITS +: BITS] = shiftReg[g];
    end

    // Publish the completed frame and one-cycle edge masks in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buttons      <= '0;
            buttonsValid <= 1'b0;
            pressedEvt   <= '0;
            releasedEvt  <= '0;
        end else begin
            buttonsValid <= 1'b0;
            pressedEvt   <= '0;
            releasedEvt  <= '0;
            if (state == DONE) begin
                buttons      <= frameBits;
                buttonsValid <= 1'b1;
                pressedEvt   <= frameBits & ~buttons;
                releasedEvt  <= ~frameBits & buttons;
            end
        end
    end

endmodule

// File: tb/tb_nes_multi_pad_poller.sv
// tb_nes_multi_pad_poller: two pollers (auto 2x8-bit, manual 1x16-bit)
// against pad models and a frame-schedule model of the pin waveform.
module tb_nes_multi_pad_poller;

    localparam int D = 4;
    localparam int P = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b0;
    logic        rst1 = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [1:0]  data0;
    logic [0:0]  data1;
    logic        latch0, nclk0, valid0, busy0;
    logic        latch1, nclk1, valid1, busy1;
    logic [15:0] btn0, prs0, rel0;
    logic [15:0] btn1, prs1, rel1;

    nes_multi_pad_poller #(
        .NUM_PADS(2), .BITS(8), .CLK_DIV(D),
        .POLL_TICKS(P), .AUTO_POLL(1)
    ) dut0 (
        .clk(clk), .reset(rst0), .nesData(data0), .pollReq(req0),
        .nesLatch(latch0), .nesClk(nclk0), .buttons(btn0),
        .buttonsValid(valid0), .pressedEvt(prs0),
        .releasedEvt(rel0), .busy(busy0)
    );

    nes_multi_pad_poller #(
        .NUM_PADS(1), .BITS(16), .CLK_DIV(D),
        .POLL_TICKS(P), .AUTO_POLL(0)
    ) dut1 (
        .clk(clk), .reset(rst1), .nesData(data1), .pollReq(req1),
        .nesLatch(latch1), .nesClk(nclk1), .buttons(btn1),
        .buttonsValid(valid1), .pressedEvt(prs1),
        .releasedEvt(rel1), .busy(busy1)
    );

    // Pad models: latch reloads, each rising clock advances one bit.
    logic [7:0]  padVal0 [2];
    logic [1:0]  plug0;
    logic [15:0] padVal1;
    int pIdx0 = 0;
    int pIdx1 = 0;

    always @(posedge nclk0 or posedge latch0) begin
        if (latch0) pIdx0 = 0;
        else pIdx0 = pIdx0 + 1;
    end

    always @(posedge nclk1 or posedge latch1) begin
        if (latch1) pIdx1 = 0;
        else pIdx1 = pIdx1 + 1;
    end

    assign data0[0] = (plug0[0] && pIdx0 < 8) ? ~padVal0[0][pIdx0[2:0]] : 1'b1;
    assign data0[1] = (plug0[1] && pIdx0 < 8) ? ~padVal0[1][pIdx0[2:0]] : 1'b1;
    assign data1[0] = (pIdx1 < 16) ? ~padVal1[pIdx1[3:0]] : 1'b1;

    // Uniform views of both instances.
    logic        aRst [2], aReq [2], aLatch [2], aClk [2];
    logic        aValid [2], aBusy [2];
    logic [15:0] aBtn [2], aPrs [2], aRel [2];
    assign aRst[0] = rst0;     assign aRst[1] = rst1;
    assign aReq[0] = req0;     assign aReq[1] = req1;
    assign aLatch[0] = latch0; assign aLatch[1] = latch1;
    assign aClk[0] = nclk0;    assign aClk[1] = nclk1;
    assign aValid[0] = valid0; assign aValid[1] = valid1;
    assign aBusy[0] = busy0;   assign aBusy[1] = busy1;
    assign aBtn[0] = btn0;     assign aBtn[1] = btn1;
    assign aPrs[0] = prs0;     assign aPrs[1] = prs1;
    assign aRel[0] = rel0;     assign aRel[1] = rel1;

    int bitsOf [2] = '{8, 16};
    int autoOf [2] = '{1, 0};

    int nCmp = 0;
    int nBad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] frameVal(input int i);
        logic [7:0] lo, hi;
        lo = plug0[0] ? padVal0[0] : 8'h00;
        hi = plug0[1] ? padVal0[1] : 8'h00;
        return (i == 0) ? {hi, lo} : padVal1;
    endfunction

    function automatic int ceilD(input int x);
        return ((x + D - 1) / D) * D;
    endfunction

    // P-th tick edge after the edge where IDLE was entered.
    function automatic int autoStart(input int e);
        return ((e / D) + 1) * D + (P - 1) * D;
    endfunction

    // Frame-schedule model: edges counted from reset release; a frame
    // starting at edge S occupies fixed tick-aligned windows after S.
    int          n [2];
    int          sEdge [2];
    logic [15:0] mBtn [2];
    logic        eLatch [2], eClk [2], eBusy [2], eValid [2];
    logic [15:0] ePrs [2], eRel [2];

    always @(posedge clk) begin : model
        int r, fl;
        logic [15:0] fv;
        for (int i = 0; i < 2; i++) begin
            eLatch[i] = 1'b0;
            eClk[i]   = 1'b1;
            eBusy[i]  = 1'b0;
            eValid[i] = 1'b0;
            ePrs[i]   = '0;
            eRel[i]   = '0;
            if (!aRst[i]) begin
                n[i]     = 0;
                sEdge[i] = autoOf[i] != 0 ? autoStart(0) : -1;
                mBtn[i]  = '0;
            end else begin
                n[i]++;
                fl = (2 * bitsOf[i] + 1) * D;
                if ((sEdge[i] < 0 || n[i] <= sEdge[i]) && aReq[i] &&
                    (sEdge[i] < 0 || ceilD(n[i]) < sEdge[i]))
                    sEdge[i] = ceilD(n[i]);
                r = (sEdge[i] >= 0 && n[i] >= sEdge[i]) ? n[i] - sEdge[i] : -1;
                if (r == fl + 1) begin
                    fv        = frameVal(i);
                    eValid[i] = 1'b1;
                    ePrs[i]   = fv & ~mBtn[i];
                    eRel[i]   = ~fv & mBtn[i];
                    mBtn[i]   = fv;
                    sEdge[i]  = autoOf[i] != 0 ? autoStart(n[i]) : -1;
                end else if (r >= 0 && r < 2 * D) begin
                    eLatch[i] = 1'b1;
                    eBusy[i]  = 1'b1;
                end else if (r >= 2 * D && r < fl) begin
                    eBusy[i] = 1'b1;
                    eClk[i]  = (((r - 2 * D) / D) % 2) == 0;
                end else if (r == fl) begin
                    eBusy[i] = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model (or reset values).
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!aRst[i]) begin
                check($sformatf("rLatch%0d", i), aLatch[i], 0);
                check($sformatf("rClk%0d", i), aClk[i], 1);
                check($sformatf("rBusy%0d", i), aBusy[i], 0);
                check($sformatf("rValid%0d", i), aValid[i], 0);
                check($sformatf("rBtn%0d", i), aBtn[i], 0);
            end else begin
                check($sformatf("latch%0d", i), aLatch[i], eLatch[i]);
                check($sformatf("nesClk%0d", i), aClk[i], eClk[i]);
                check($sformatf("busy%0d", i), aBusy[i], eBusy[i]);
                check($sformatf("valid%0d", i), aValid[i], eValid[i]);
                check($sformatf("btn%0d", i), aBtn[i], mBtn[i]);
                check($sformatf("prs%0d", i), aPrs[i], ePrs[i]);
                check($sformatf("rel%0d", i), aRel[i], eRel[i]);
            end
        end
    end

    // Waveform measurements for the literal checks.
    int   edgeN [2], riseN [2], latchLen [2], lows [2];
    int   badLow [2], curLow [2], lat2v [2];
    int   rises [2] = '{0, 0};
    logic pL [2], pC [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!aRst[i]) begin
                edgeN[i]  = 0;
                pL[i]     = 1'b0;
                pC[i]     = 1'b1;
                curLow[i] = 0;
            end else begin
                edgeN[i]++;
                if (aLatch[i] && !pL[i]) begin
                    riseN[i]    = edgeN[i];
                    latchLen[i] = 0;
                    lows[i]     = 0;
                    badLow[i]   = 0;
                    rises[i]++;
                end
                if (aLatch[i]) latchLen[i]++;
                if (!aClk[i]) curLow[i]++;
                if (aClk[i] && !pC[i]) begin
                    lows[i]++;
                    if (curLow[i] != D) badLow[i]++;
                    curLow[i] = 0;
                end
                if (aValid[i]) lat2v[i] = edgeN[i] - riseN[i];
                pL[i] = aLatch[i];
                pC[i] = aClk[i];
            end
        end
    end

    task automatic waitValid(input int i, input int budget,
                             output logic [15:0] b, output logic [15:0] p,
                             output logic [15:0] r);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!aValid[i] && k < budget);
        check($sformatf("vWait%0d", i), aValid[i], 1);
        b = aBtn[i];
        p = aPrs[i];
        r = aRel[i];
        #1;
    endtask

    initial begin : stim
        logic [15:0] b, p, r;
        int k;
        padVal0[0] = 8'h01;
        padVal0[1] = 8'h80;
        plug0      = 2'b11;
        padVal1    = 16'hA55A;

        repeat (3) @(negedge clk);
        check("initBtn", btn0, 0);
        check("initLatch", latch0, 0);
        check("initClk", nclk0, 1);
        check("initBusy", busy0, 0);
        #2;
        rst0 = 1'b1;
        rst1 = 1'b1;

        waitValid(0, 200, b, p, r);
        check("f1Btn", b, 16'h8001);
        check("f1Prs", p, 16'h8001);
        check("f1Rel", r, 16'h0000);
        check("f1Rise", riseN[0], 12);
        check("f1LatchLen", latchLen[0], 8);
        check("f1Lows", lows[0], 7);
        check("f1LowLen", badLow[0], 0);
        check("f1Lat2v", lat2v[0], 69);

        waitValid(0, 200, b, p, r);
        check("f2Btn", b, 16'h8001);
        check("f2Prs", p, 16'h0000);
        check("f2Rel", r, 16'h0000);

        padVal0[0] = 8'h02;
        waitValid(0, 200, b, p, r);
        check("f3Btn", b, 16'h8002);
        check("f3Prs", p, 16'h0002);
        check("f3Rel", r, 16'h0001);
        @(negedge clk);
        check("f3PrsClr", prs0, 16'h0000);
        check("f3RelClr", rel0, 16'h0000);
        check("f3VldClr", valid0, 0);

        plug0[1] = 1'b0;
        waitValid(0, 200, b, p, r);
        check("f4Btn", b, 16'h0002);
        check("f4Prs", p, 16'h0000);
        check("f4Rel", r, 16'h8000);

        plug0[1] = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(busy0 && !nclk0) && k < 200);
        check("pulseSeen", busy0 && !nclk0, 1);
        #2;
        rst0 = 1'b0;
        #1;
        check("abClk", nclk0, 1);
        check("abLatch", latch0, 0);
        check("abBtn", btn0, 0);
        check("abBusy", busy0, 0);
        check("abValid", valid0, 0);
        repeat (2) @(negedge clk);
        #2;
        rst0 = 1'b1;
        waitValid(0, 200, b, p, r);
        check("f5Btn", b, 16'h8002);
        check("f5Prs", p, 16'h8002);
        check("f5Rise", riseN[0], 12);
        check("f5Lat2v", lat2v[0], 69);

        repeat (1000) @(negedge clk);
        #1;
        check("manIdle", rises[1], 0);

        req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        waitValid(1, 300, b, p, r);
        check("m1Btn", b, 16'hA55A);
        check("m1Prs", p, 16'hA55A);
        check("m1Rel", r, 16'h0000);
        check("m1Lows", lows[1], 15);
        check("m1LowLen", badLow[1], 0);
        check("m1LatchLen", latchLen[1], 8);
        check("m1Lat2v", lat2v[1], 133);
        check("m1Rises", rises[1], 1);

        padVal1 = 16'h5AA5;
        req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(busy1 && !latch1 && nclk1) && k < 200);
        check("readSeen", busy1 && !latch1 && nclk1, 1);
        req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        waitValid(1, 300, b, p, r);
        check("m2Btn", b, 16'h5AA5);
        check("m2Prs", p, 16'h5AA5);
        check("m2Rel", r, 16'hA55A);
        repeat (200) @(negedge clk);
        #1;
        check("m2Rises", rises[1], 2);

        req1 = 1'b1;
        waitValid(1, 300, b, p, r);
        check("m3Btn", b, 16'h5AA5);
        waitValid(1, 300, b, p, r);
        req1 = 1'b0;
        check("m4Prs", p, 16'h0000);
        repeat (200) @(negedge clk);
        #1;
        check("m4Rises", rises[1], 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
